// File: rtl/circuito_jogo_param_pkg.sv
// Shared definitions for the parametrised sequence-memory game: state codes
// and the width helpers used to size the address and timer counters.
package circuito_jogo_param_pkg;

  localparam logic [3:0] ST_INICIAL        = 4'h0;
  localparam logic [3:0] ST_PREPARA        = 4'h1;
  localparam logic [3:0] ST_MOSTRA         = 4'h2;
  localparam logic [3:0] ST_PAUSA          = 4'h3;
  localparam logic [3:0] ST_ESPERA         = 4'h4;
  localparam logic [3:0] ST_REGISTRA       = 4'h5;
  localparam logic [3:0] ST_COMPARA        = 4'h6;
  localparam logic [3:0] ST_PROXIMA_JOGADA = 4'h7;
  localparam logic [3:0] ST_PROXIMA_RODADA = 4'h8;
  localparam logic [3:0] ST_FIM_GANHOU     = 4'hA;
  localparam logic [3:0] ST_FIM_PERDEU     = 4'hE;

  // Address width for a memory of 'prof' words (never narrower than 1 bit).
  function automatic int largura_endereco(input int prof);
    return (prof < 2) ? 1 : $clog2(prof);
  endfunction

  // Width of a counter that must reach max(a, b) - 1.
  function automatic int largura_contador(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/circuito_jogo_param_memoria_sequencia.sv
// Sequence memory: PROF words of N_BOTOES bits, synchronous write,
// asynchronous read. Each word stores only its difference from the load
// pattern 0001, 0010, 0100, 1000, ... so flops that power up at zero read
// back as that pattern without needing a reset; reset never touches it.
module memoria_sequencia
  import circuito_jogo_param_pkg::*;
#(
  parameter int N_BOTOES = 4,
  parameter int PROF     = 16,
  parameter int ADDR_W   = largura_endereco(PROF)
) (
  input  logic                clock,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [N_BOTOES-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [N_BOTOES-1:0] rdata
);

  localparam int PERIODO = (N_BOTOES < 4) ? N_BOTOES : 4;

  function automatic logic [N_BOTOES-1:0] valor_inicial(input int indice);
    return N_BOTOES'(1) << (indice % PERIODO);
  endfunction

  logic [N_BOTOES-1:0] palavra [PROF];

  for (genvar i = 0; i < PROF; i++) begin : g_palavra
    localparam logic [N_BOTOES-1:0] CARGA = valor_inicial(i);
    logic [N_BOTOES-1:0] delta_q;
    logic [N_BOTOES-1:0] delta_d;

    // A write to this word replaces its stored difference from the load value.
    always_comb begin
      delta_d = delta_q;
      if (we && (waddr == ADDR_W'(i))) begin
        delta_d = wdata ^ CARGA;
      end
    end

    // Storage flop, deliberately without reset so contents survive a game reset.
    always_ff @(posedge clock) begin
      delta_q <= delta_d;
    end

    assign palavra[i] = delta_q ^ CARGA;
  end

  assign rdata = palavra[raddr];

endmodule

// File: rtl/circuito_jogo_param.sv
// Parametrised sequence-memory game: shows a growing stored sequence on the
// LEDs, then checks the player's presses against it with a per-move timeout.
module circuito_jogo_param
  import circuito_jogo_param_pkg::*;
#(
  parameter int N_BOTOES       = 4,
  parameter int PROF           = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int MOSTRA_CICLOS  = 1000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     jogar,
  input  logic [N_BOTOES-1:0]      botoes,
  input  logic                     mem_we,
  input  logic [$clog2(PROF)-1:0]  mem_addr,
  input  logic [N_BOTOES-1:0]      mem_data,
  output logic [N_BOTOES-1:0]      leds,
  output logic                     ganhou,
  output logic                     perdeu,
  output logic                     pronto,
  output logic [3:0]               db_estado,
  output logic [$clog2(PROF)-1:0]  db_rodada,
  output logic                     db_timeout
);

  localparam int ADDR_W  = largura_endereco(PROF);
  localparam int TEMPO_W = largura_contador(TIMEOUT_CICLOS, MOSTRA_CICLOS);
  localparam logic [TEMPO_W-1:0] FIM_MOSTRA    = TEMPO_W'(MOSTRA_CICLOS - 1);
  localparam logic [TEMPO_W-1:0] FIM_ESPERA    = TEMPO_W'(TIMEOUT_CICLOS - 1);
  localparam logic [ADDR_W-1:0]  ULTIMA_RODADA = ADDR_W'(PROF - 1);

  logic [3:0]          estado_q, estado_d;
  logic [ADDR_W-1:0]   rodada_q, rodada_d;
  logic [ADDR_W-1:0]   endereco_q, endereco_d;
  logic [TEMPO_W-1:0]  tempo_q, tempo_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic [N_BOTOES-1:0] botoes_reg_q, botoes_reg_d;
  logic                borda_q, borda_d;
  logic                timeout_q, timeout_d;

  logic [N_BOTOES-1:0] dado_lido;
  logic                escrita;
  logic                jogada_um_quente;
  logic                jogada_correta;

  assign escrita = mem_we && (estado_q == ST_INICIAL);

  memoria_sequencia #(
    .N_BOTOES (N_BOTOES),
    .PROF     (PROF),
    .ADDR_W   (ADDR_W)
  ) u_memoria (
    .clock (clock),
    .we    (escrita),
    .waddr (mem_addr),
    .wdata (mem_data),
    .raddr (endereco_q),
    .rdata (dado_lido)
  );

  assign jogada_um_quente = (jogada_q != '0) &&
                            ((jogada_q & (jogada_q - N_BOTOES'(1))) == '0);
  assign jogada_correta   = jogada_um_quente && (jogada_q == dado_lido);

  // Press detector: a move is buttons going from all-released to anything
  // pressed, so a button held across states never yields a second move.
  always_comb begin
    botoes_reg_d = botoes;
    borda_d      = (botoes != '0) && (botoes_reg_q == '0);
  end

  // Game controller: next state plus round, display index, timer and move updates.
  always_comb begin
    estado_d   = estado_q;
    rodada_d   = rodada_q;
    endereco_d = endereco_q;
    tempo_d    = tempo_q;
    jogada_d   = jogada_q;
    timeout_d  = timeout_q;
    case (estado_q)
      ST_INICIAL: begin
        if (jogar) estado_d = ST_PREPARA;
      end
      ST_PREPARA: begin
        rodada_d   = '0;
        endereco_d = '0;
        tempo_d    = '0;
        jogada_d   = '0;
        timeout_d  = 1'b0;
        estado_d   = ST_MOSTRA;
      end
      ST_MOSTRA: begin
        if (tempo_q == FIM_MOSTRA) begin
          tempo_d  = '0;
          estado_d = ST_PAUSA;
        end else begin
          tempo_d = tempo_q + TEMPO_W'(1);
        end
      end
      ST_PAUSA: begin
        if (tempo_q == FIM_MOSTRA) begin
          tempo_d = '0;
          if (endereco_q == rodada_q) begin
            endereco_d = '0;
            estado_d   = ST_ESPERA;
          end else begin
            endereco_d = endereco_q + ADDR_W'(1);
            estado_d   = ST_MOSTRA;
          end
        end else begin
          tempo_d = tempo_q + TEMPO_W'(1);
        end
      end
      ST_ESPERA: begin
        if (borda_q) begin
          jogada_d = botoes;
          estado_d = ST_REGISTRA;
        end else if (tempo_q == FIM_ESPERA) begin
          timeout_d = 1'b1;
          estado_d  = ST_FIM_PERDEU;
        end else begin
          tempo_d = tempo_q + TEMPO_W'(1);
        end
      end
      ST_REGISTRA: begin
        estado_d = ST_COMPARA;
      end
      ST_COMPARA: begin
        if (!jogada_correta) begin
          estado_d = ST_FIM_PERDEU;
        end else if (endereco_q < rodada_q) begin
          estado_d = ST_PROXIMA_JOGADA;
        end else if (rodada_q == ULTIMA_RODADA) begin
          estado_d = ST_FIM_GANHOU;
        end else begin
          estado_d = ST_PROXIMA_RODADA;
        end
      end
      ST_PROXIMA_JOGADA: begin
        endereco_d = endereco_q + ADDR_W'(1);
        tempo_d    = '0;
        estado_d   = ST_ESPERA;
      end
      ST_PROXIMA_RODADA: begin
        rodada_d   = rodada_q + ADDR_W'(1);
        endereco_d = '0;
        tempo_d    = '0;
        estado_d   = ST_MOSTRA;
      end
      ST_FIM_GANHOU, ST_FIM_PERDEU: begin
        if (jogar) estado_d = ST_PREPARA;
      end
      default: begin
        estado_d = ST_INICIAL;
      end
    endcase
  end

  // State and datapath registers; reset returns to the idle state with every counter cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= ST_INICIAL;
      rodada_q     <= '0;
      endereco_q   <= '0;
      tempo_q      <= '0;
      jogada_q     <= '0;
      botoes_reg_q <= '0;
      borda_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      rodada_q     <= rodada_d;
      endereco_q   <= endereco_d;
      tempo_q      <= tempo_d;
      jogada_q     <= jogada_d;
      botoes_reg_q <= botoes_reg_d;
      borda_q      <= borda_d;
      timeout_q    <= timeout_d;
    end
  end

  // Outputs decoded from state: stored sequence while showing, the move echo while registering.
  always_comb begin
    leds = '0;
    if (estado_q == ST_MOSTRA) begin
      leds = dado_lido;
    end else if (estado_q == ST_REGISTRA) begin
      leds = jogada_q;
    end
  end

  assign ganhou     = (estado_q == ST_FIM_GANHOU);
  assign perdeu     = (estado_q == ST_FIM_PERDEU);
  assign pronto     = ganhou || perdeu;
  assign db_estado  = estado_q;
  assign db_rodada  = rodada_q;
  assign db_timeout = timeout_q && perdeu;

endmodule
